// File: rtl/iram_ctrl.sv
// Instruction RAM controller: arbitrates one fetch port and one load port
// onto a single bidirectional RAM bus.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   fetch_req/addr -> fetch_valid/instr/err   read requester
//   load_req/addr/data -> load_ack/err        write requester
//   mem_address, mem_data (inout), mem_read_not_write   RAM side
//   busy                             high while a transaction is in flight
module iram_ctrl #(
  parameter int ADDRESS_BUS_WIDTH = 24,
  parameter int INSTRUCTION_WIDTH = 33,
  parameter int NUM_INSTR_WORDS   = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fetch_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr,
  output logic                         fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instr,
  output logic                         fetch_err,
  input  logic                         load_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] load_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  output logic                         load_ack,
  output logic                         load_err,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  inout  wire  [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic                         mem_read_not_write,
  output logic                         busy
);

  localparam logic [ADDRESS_BUS_WIDTH-1:0] LIMIT =
    ADDRESS_BUS_WIDTH'(NUM_INSTR_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    WR
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic                   prio_f;
  logic                   prio_f_nx;
  logic                   ok;
  logic                   ok_nx;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_q;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_nx;
  logic                   f_elig;
  logic                   l_elig;
  logic                   grant_f;
  logic                   grant_l;
  logic                   wr_en;

  // A requester whose completion pulse is showing is still holding req
  // from the finished transaction; it must not be granted again.
  assign f_elig = fetch_req && !fetch_valid;
  assign l_elig = load_req && !load_ack;

  always_comb begin
    state_nx  = state;
    prio_f_nx = prio_f;
    ok_nx     = ok;
    addr_nx   = addr_q;
    grant_f   = 1'b0;
    grant_l   = 1'b0;
    unique case (state)
      IDLE: begin
        if (f_elig && l_elig) begin
          grant_f   = prio_f;
          grant_l   = !prio_f;
          prio_f_nx = !prio_f;
        end else begin
          grant_f = f_elig;
          grant_l = l_elig;
        end
        if (grant_f) begin
          state_nx = RD_ADDR;
          addr_nx  = fetch_addr;
          ok_nx    = fetch_addr < LIMIT;
        end else if (grant_l) begin
          state_nx = WR;
          addr_nx  = load_addr;
          ok_nx    = load_addr < LIMIT;
        end
      end
      RD_ADDR: state_nx = RD_WAIT;
      RD_WAIT: state_nx = IDLE;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      prio_f      <= 1'b1;
      ok          <= 1'b0;
      addr_q      <= '0;
      busy        <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_instr <= '0;
      load_ack    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      prio_f      <= prio_f_nx;
      ok          <= ok_nx;
      addr_q      <= addr_nx;
      busy        <= state_nx != IDLE;
      fetch_valid <= state == RD_WAIT;
      fetch_err   <= state == RD_WAIT && !ok;
      load_ack    <= state == WR;
      load_err    <= state == WR && !ok;
      if (state == RD_WAIT)
        fetch_instr <= ok ? mem_data : '0;
    end
  end

  // Write strobe is decoded from the state so an async reset drops it
  // immediately.
  assign wr_en              = state == WR && ok;
  assign mem_read_not_write = !wr_en;
  assign mem_data           = wr_en ? load_data : 'z;
  assign mem_address        = addr_q;

endmodule

// File: tb/tb_iram_ctrl.sv
// Self-checking bench for iram_ctrl: RAM model on the bus, transaction
// level reference memory and round-robin model.
module tb_iram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [23:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [32:0] fetch_instr;
  logic        fetch_err;
  logic        load_req = 1'b0;
  logic [23:0] load_addr = '0;
  logic [32:0] load_data = '0;
  logic        load_ack;
  logic        load_err;
  logic [23:0] mem_address;
  wire  [32:0] mem_data;
  logic        mem_read_not_write;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [32:0] ram [64];
  logic [32:0] ref_mem [64];
  logic        prio_m;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_a = '0;
  logic [32:0] pre_d = '0;
  logic        ram_oe;

  iram_ctrl #(
    .ADDRESS_BUS_WIDTH(24),
    .INSTRUCTION_WIDTH(33),
    .NUM_INSTR_WORDS(64)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_err(fetch_err),
    .load_req(load_req),
    .load_addr(load_addr),
    .load_data(load_data),
    .load_ack(load_ack),
    .load_err(load_err),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_read_not_write(mem_read_not_write),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign ram_oe = busy && mem_read_not_write && (mem_address < 24'd64);
  assign mem_data = ram_oe ? ram[mem_address[5:0]] : 'z;

  always @(posedge clk) begin
    if (pre_we)
      ram[pre_a] <= pre_d;
    else if (!mem_read_not_write && mem_address < 24'd64)
      ram[mem_address[5:0]] <= mem_data;
  end

  // Bus and qualifier monitor over every scenario.
  always @(negedge clk) begin
    if (mem_read_not_write && !ram_oe) begin
      total++;
      if (mem_data !== {33{1'bz}}) begin
        bad++;
        $display("FAIL bus_z: mem_data=%h want z", mem_data);
      end
    end
    if (!fetch_valid && fetch_err) begin
      bad++;
      $display("FAIL fetch_err_idle: got 1 want 0");
    end
    if (!load_ack && load_err) begin
      bad++;
      $display("FAIL load_err_idle: got 1 want 0");
    end
  end

  function automatic logic [32:0] rnd33();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[32:0];
  endfunction

  task automatic preload(input int a, input logic [32:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = 6'(a);
    pre_d  = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One fetch and/or load, with expected order, latency and data.
  task automatic run_txn(input bit df, input bit dl,
                         input logic [23:0] fa, input logic [23:0] la,
                         input logic [32:0] ld);
    bit fp, lp, fwin;
    int nf, nl, wrc, ef, el;
    logic [32:0] ei;
    fp = df; lp = dl; nf = 0; nl = 0; wrc = 0;
    fwin = df && (!dl || prio_m);
    if (df && dl) prio_m = !prio_m;
    ef = !df ? 0 : (!dl ? 3 : (fwin ? 3 : 5));
    el = !dl ? 0 : (!df ? 2 : (fwin ? 5 : 2));
    @(negedge clk);
    fetch_addr = fa; load_addr = la; load_data = ld;
    fetch_req = df; load_req = dl;
    for (int n = 1; n <= 12 && (fp || lp); n++) begin
      @(negedge clk);
      if (!mem_read_not_write) begin
        wrc++;
        total++;
        if (mem_address !== la || mem_data !== ld) begin
          bad++;
          $display("FAIL wr_bus: addr=%h data=%h want %h %h",
                   mem_address, mem_data, la, ld);
        end
      end
      if (load_ack) begin
        if (!lp) begin
          bad++;
          $display("FAIL spurious_ack at n=%0d", n);
        end else begin
          lp = 0; load_req = 1'b0; nl = n;
          if (la < 64) ref_mem[la[5:0]] = ld;
          total++;
          if (load_err !== (la >= 64)) begin
            bad++;
            $display("FAIL load_err: got %b want %b", load_err, la >= 64);
          end
        end
      end
      if (fetch_valid) begin
        if (!fp) begin
          bad++;
          $display("FAIL spurious_valid at n=%0d", n);
        end else begin
          fp = 0; fetch_req = 1'b0; nf = n;
          ei = (fa < 64) ? ref_mem[fa[5:0]] : '0;
          total++;
          if (fetch_instr !== ei || fetch_err !== (fa >= 64)) begin
            bad++;
            $display("FAIL fetch_data: got %h err %b want %h err %b",
                     fetch_instr, fetch_err, ei, fa >= 64);
          end
        end
      end
    end
    total++;
    if (fp || lp) begin
      bad++;
      $display("FAIL txn_timeout: pending f=%b l=%b want none", fp, lp);
      fetch_req = 1'b0; load_req = 1'b0;
    end
    total++;
    if (nf != ef || nl != el) begin
      bad++;
      $display("FAIL latency: f=%0d l=%0d want %0d %0d", nf, nl, ef, el);
    end
    total++;
    if (wrc != ((dl && la < 64) ? 1 : 0)) begin
      bad++;
      $display("FAIL wr_cycles: got %0d want %0d", wrc, (dl && la < 64));
    end
    @(negedge clk);
    total++;
    if (fetch_valid || load_ack || busy) begin
      bad++;
      $display("FAIL after_txn: v=%b a=%b b=%b want 0 0 0",
               fetch_valid, load_ack, busy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) preload(i, rnd33());
    preload(5, 33'h0_1200_0020);
    total++;
    if (fetch_valid !== 1'b0 || fetch_instr !== '0 || fetch_err !== 1'b0 ||
        load_ack !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0 ||
        mem_address !== '0 || mem_read_not_write !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: v=%b i=%h a=%b b=%b ma=%h rnw=%b",
               fetch_valid, fetch_instr, load_ack, busy,
               mem_address, mem_read_not_write);
    end
    @(negedge clk);
    reset_n = 1'b1;
    prio_m = 1'b1;
  endtask

  task automatic test_back_to_back();
    int ev;
    bit exp_f;
    logic [32:0] ld;
    ev = 0; exp_f = 1'b1; ld = rnd33();
    @(negedge clk);
    fetch_addr = 24'd5; load_addr = 24'd7; load_data = ld;
    fetch_req = 1'b1; load_req = 1'b1;
    prio_m = !prio_m;
    for (int n = 0; n < 40 && ev < 8; n++) begin
      @(negedge clk);
      if (fetch_valid || load_ack) begin
        total++;
        if (fetch_valid !== exp_f || load_ack !== !exp_f) begin
          bad++;
          $display("FAIL rr_order ev%0d: v=%b a=%b want fetch=%b",
                   ev, fetch_valid, load_ack, exp_f);
        end
        if (load_ack) ref_mem[7] = ld;
        if (fetch_valid) begin
          total++;
          if (fetch_instr !== ref_mem[5]) begin
            bad++;
            $display("FAIL rr_data: got %h want %h", fetch_instr, ref_mem[5]);
          end
        end
        exp_f = !exp_f;
        ev++;
        if (ev == 8) begin
          fetch_req = 1'b0; load_req = 1'b0;
        end
      end
    end
    total++;
    if (ev < 8) begin
      bad++;
      $display("FAIL rr_timeout: events=%0d want 8", ev);
      fetch_req = 1'b0; load_req = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fetch();
    run_txn(1, 0, 24'd5, 24'd0, '0);
  endtask

  task automatic test_load();
    run_txn(0, 1, 24'd0, 24'd3, 33'h0_5221_0000);
    run_txn(1, 0, 24'd3, 24'd0, '0);
  endtask

  task automatic test_out_of_range();
    run_txn(0, 1, 24'd0, 24'd64, rnd33());
    run_txn(1, 0, 24'd70, 24'd0, '0);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (ram[i] !== ref_mem[i]) begin
        bad++;
        $display("FAIL oor_ram[%0d]: got %h want %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset_wr();
    logic [32:0] ld;
    ld = ~ref_mem[10];
    @(negedge clk);
    load_addr = 24'd10; load_data = ld; load_req = 1'b1;
    @(negedge clk);
    total++;
    if (mem_read_not_write !== 1'b0) begin
      bad++;
      $display("FAIL rst_wr_enter: rnw=%b want 0", mem_read_not_write);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (mem_read_not_write !== 1'b1 || busy !== 1'b0 || load_ack !== 1'b0 ||
        mem_address !== '0) begin
      bad++;
      $display("FAIL rst_async: rnw=%b busy=%b ack=%b ma=%h want 1 0 0 0",
               mem_read_not_write, busy, load_ack, mem_address);
    end
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    prio_m = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      total++;
      if (load_ack !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_ack: ack=%b want 0", load_ack);
      end
    end
    total++;
    if (ram[10] !== ref_mem[10]) begin
      bad++;
      $display("FAIL rst_word: got %h want %h", ram[10], ref_mem[10]);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      run_txn(k != 1, k != 0,
              24'($urandom_range(0, 79)), 24'($urandom_range(0, 79)),
              rnd33());
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (ram[i] !== ref_mem[i]) begin
        bad++;
        $display("FAIL final_ram[%0d]: got %h want %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_fetch();
    test_load();
    test_out_of_range();
    test_reset_wr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
